// File: rtl/sfp_frame_rx.sv
// sfp_frame_rx: sync-hunting deserializer for the CDR bit stream, with bit-gap watchdog and link qualifier.
// Optional feature: define SFP_FRAME_RX_CRC8_EN to append and check a CRC-8 (poly 0x07) after the payload.
module sfp_frame_rx #(
  parameter int                DATA_W    = 16,
  parameter int                SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA7,
  parameter int                GAP_MAX   = 16,
  parameter int                LINK_GOOD = 4
) (
  input  logic              i_clk,
  input  logic              i_res,
  input  logic              i_RecoveryData,
  input  logic              i_DataEn,
  output logic [DATA_W-1:0] o_Data,
  output logic              o_DataValid,
  output logic              o_FrameErr,
  output logic              o_LinkUp
);
  localparam int CNT_MAX = (DATA_W > 8) ? DATA_W : 8;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int GAP_W   = $clog2(GAP_MAX + 1);
  localparam int GOOD_W  = $clog2(LINK_GOOD + 1);

`ifdef SFP_FRAME_RX_CRC8_EN
  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;
`else
  typedef enum logic [1:0] {HUNT, PAYLOAD} state_t;
`endif

  state_t            state;
  logic [SYNC_W-2:0] syncShreg;
  logic [DATA_W-2:0] payShreg;
  logic [CNT_W-1:0]  bitCnt;
  logic [GAP_W-1:0]  gapCnt;
  logic [GOOD_W-1:0] goodCnt;

  logic [SYNC_W-1:0] syncNext;
  logic [DATA_W-1:0] payNext;
  logic [GOOD_W-1:0] goodInc;
  logic              gapHit;
  logic              lastPayBit;
  logic              linkNext;

  assign syncNext   = {syncShreg, i_RecoveryData};
  assign payNext    = {payShreg, i_RecoveryData};
  // Fires on the edge where the idle counter steps onto GAP_MAX; a strobe always clears it instead.
  assign gapHit     = !i_DataEn && (gapCnt == GAP_W'(GAP_MAX - 1));
  assign lastPayBit = (bitCnt == CNT_W'(DATA_W - 1));
  assign goodInc    = (goodCnt == GOOD_W'(LINK_GOOD)) ? goodCnt : goodCnt + GOOD_W'(1);
  assign linkNext   = (goodCnt >= GOOD_W'(LINK_GOOD - 1));

`ifdef SFP_FRAME_RX_CRC8_EN
  logic [DATA_W-1:0] payWord;
  logic [7:0]        crcCalc;
  logic [7:0]        crcNext;
  logic [6:0]        crcRx;
  logic              crcFb;

  assign crcFb   = crcCalc[7] ^ i_RecoveryData;
  assign crcNext = {crcCalc[6:0], 1'b0} ^ (crcFb ? 8'h07 : 8'h00);
`endif

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      state       <= HUNT;
      syncShreg   <= '0;
      payShreg    <= '0;
      bitCnt      <= '0;
      gapCnt      <= '0;
      goodCnt     <= '0;
      o_Data      <= '0;
      o_DataValid <= 1'b0;
      o_FrameErr  <= 1'b0;
      o_LinkUp    <= 1'b0;
`ifdef SFP_FRAME_RX_CRC8_EN
      payWord     <= '0;
      crcCalc     <= '0;
      crcRx       <= '0;
`endif
    end else begin
      o_DataValid <= 1'b0;
      o_FrameErr  <= 1'b0;

      if (i_DataEn)
        gapCnt <= '0;
      else if (gapCnt != GAP_W'(GAP_MAX))
        gapCnt <= gapCnt + GAP_W'(1);

      if (gapHit) begin
        goodCnt  <= '0;
        o_LinkUp <= 1'b0;
        if (state != HUNT) begin
          o_FrameErr <= 1'b1;
          state      <= HUNT;
          syncShreg  <= '0;
        end
      end else if (i_DataEn) begin
        case (state)
          HUNT: begin
            syncShreg <= syncNext[SYNC_W-2:0];
            if (syncNext == SYNC_WORD) begin
              state  <= PAYLOAD;
              bitCnt <= '0;
`ifdef SFP_FRAME_RX_CRC8_EN
              crcCalc <= '0;
`endif
            end
          end

          PAYLOAD: begin
            payShreg <= payNext[DATA_W-2:0];
            bitCnt   <= bitCnt + CNT_W'(1);
`ifdef SFP_FRAME_RX_CRC8_EN
            crcCalc  <= crcNext;
            if (lastPayBit) begin
              payWord <= payNext;
              state   <= CHECK;
              bitCnt  <= '0;
            end
`else
            if (lastPayBit) begin
              o_Data      <= payNext;
              o_DataValid <= 1'b1;
              goodCnt     <= goodInc;
              o_LinkUp    <= linkNext;
              state       <= HUNT;
              syncShreg   <= '0;
            end
`endif
          end

`ifdef SFP_FRAME_RX_CRC8_EN
          CHECK: begin
            crcRx  <= {crcRx[5:0], i_RecoveryData};
            bitCnt <= bitCnt + CNT_W'(1);
            if (bitCnt == CNT_W'(7)) begin
              state     <= HUNT;
              syncShreg <= '0;
              if ({crcRx, i_RecoveryData} == crcCalc) begin
                o_Data      <= payWord;
                o_DataValid <= 1'b1;
                goodCnt     <= goodInc;
                o_LinkUp    <= linkNext;
              end else begin
                o_FrameErr <= 1'b1;
                goodCnt    <= '0;
                o_LinkUp   <= 1'b0;
              end
            end
          end
`endif

          default: begin
            state     <= HUNT;
            syncShreg <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sfp_frame_rx.sv
// Randomized scoreboard bench for sfp_frame_rx; frame-level reference model, decoupled pulse monitor.
module tb_sfp_frame_rx;
  localparam int DATA_W    = 16;
  localparam int GAP_MAX   = 16;
  localparam int LINK_GOOD = 4;
`ifdef SFP_FRAME_RX_CRC8_EN
  localparam int NCRC = 8;
`else
  localparam int NCRC = 0;
`endif

  logic              i_clk;
  logic              i_res;
  logic              i_RecoveryData;
  logic              i_DataEn;
  logic [DATA_W-1:0] o_Data;
  logic              o_DataValid;
  logic              o_FrameErr;
  logic              o_LinkUp;

  sfp_frame_rx dut (
    .i_clk         (i_clk),
    .i_res         (i_res),
    .i_RecoveryData(i_RecoveryData),
    .i_DataEn      (i_DataEn),
    .o_Data        (o_Data),
    .o_DataValid   (o_DataValid),
    .o_FrameErr    (o_FrameErr),
    .o_LinkUp      (o_LinkUp)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct packed {
    logic        isErr;
    logic [15:0] data;
    logic        link;
  } exp_t;

  exp_t        expQ[$];
  int          checks   = 0;
  int          failures = 0;
  int          goodCnt  = 0;
  logic [15:0] lastData = '0;
  int          spacing  = 4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference CRC-8: poly 0x07, init 0, MSB-first over the 16 payload bits.
  function automatic logic [7:0] crc8(input logic [15:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 15; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  task automatic expectGood(input logic [15:0] d);
    exp_t e;
    if (goodCnt < LINK_GOOD) goodCnt++;
    e.isErr  = 1'b0;
    e.data   = d;
    e.link   = (goodCnt == LINK_GOOD);
    lastData = d;
    expQ.push_back(e);
  endtask

  task automatic expectErr();
    exp_t e;
    goodCnt = 0;
    e.isErr = 1'b1;
    e.data  = lastData;
    e.link  = 1'b0;
    expQ.push_back(e);
  endtask

  task automatic cyc(input logic en, input logic b);
    i_DataEn       = en;
    i_RecoveryData = b;
    @(posedge i_clk);
    #1;
  endtask

  task automatic sendBit(input logic b);
    cyc(1'b1, b);
    repeat (spacing - 1) cyc(1'b0, 1'b0);
  endtask

  task automatic doReset();
    i_res    = 1'b1;
    i_DataEn = 1'b0;
    i_RecoveryData = 1'b0;
    @(posedge i_clk);
    #1;
    i_res = 1'b0;
    chk("reset_data",  32'(o_Data),      32'd0);
    chk("reset_valid", 32'(o_DataValid), 32'd0);
    chk("reset_err",   32'(o_FrameErr),  32'd0);
    chk("reset_link",  32'(o_LinkUp),    32'd0);
    goodCnt  = 0;
    lastData = '0;
  endtask

  // cut < 0: complete frame; otherwise after 'cut' post-sync bits either stall or reset.
  task automatic sendFrame(input logic [15:0] d, input logic [7:0] crc, input int cut,
                           input bit cutIsReset, input int pre);
    logic [23:0] bits;
    logic [7:0]  syncWord;
    bit          stopped;
    bits     = {d, crc};
    syncWord = 8'hA7;
    stopped  = 1'b0;
    repeat (pre) sendBit(1'b0);
    for (int i = 7; i >= 0; i--) sendBit(syncWord[i]);
    for (int i = 0; i < DATA_W + NCRC; i++) begin
      if (!stopped) begin
        if (i == cut) begin
          stopped = 1'b1;
          if (cutIsReset) doReset();
          else repeat (GAP_MAX + 2) cyc(1'b0, 1'b0);
        end else begin
          sendBit(bits[23 - i]);
        end
      end
    end
  endtask

  task automatic huntIdle();
    repeat (GAP_MAX + 4) cyc(1'b0, 1'b0);
    goodCnt = 0;
    chk("hunt_gap_link", 32'(o_LinkUp), 32'd0);
  endtask

  // Monitor: pops one expectation per output pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (o_DataValid === 1'b1 || o_FrameErr === 1'b1) begin
        chk("valid_err_exclusive", 32'(o_DataValid & o_FrameErr), 32'd0);
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: got valid=%0b err=%0b data=%h, expected no pulse",
                   o_DataValid, o_FrameErr, o_Data);
        end else begin
          e = expQ.pop_front();
          chk("pulse_is_err", 32'(o_FrameErr), 32'(e.isErr));
          chk("pulse_data",   32'(o_Data),     32'(e.data));
          chk("pulse_link",   32'(o_LinkUp),   32'(e.link));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d;
    logic [7:0]  flip;
    int          kind;
    int          pre;
    i_res = 1'b1;
    i_DataEn = 1'b0;
    i_RecoveryData = 1'b0;
    @(posedge i_clk);
    #1;
    doReset();

    spacing = 4;
    repeat (20) sendBit(1'b0);
    chk("idle_data", 32'(o_Data),   32'd0);
    chk("idle_link", 32'(o_LinkUp), 32'd0);
    $display("txn idle: 20 zero bits");

    expectGood(16'h1234);
    sendFrame(16'h1234, 8'hF1, -1, 1'b0, 2);
    $display("txn directed: data=1234 crc=f1");
`ifdef SFP_FRAME_RX_CRC8_EN
    expectErr();
    sendFrame(16'h1234, 8'hF0, -1, 1'b0, 2);
    $display("txn directed: data=1234 crc=f0 (bad)");
`endif

    for (int n = 0; n < 5; n++) begin
      d = 16'($urandom);
      expectGood(d);
      sendFrame(d, crc8(d), -1, 1'b0, 0);
      $display("txn back-to-back good %0d: data=%h", n, d);
    end

    d = 16'($urandom);
    expectErr();
    sendFrame(d, crc8(d), 5, 1'b0, 1);
    $display("txn stall after 5 payload bits");

    expectGood(16'h5A3C);
    sendFrame(16'h5A3C, crc8(16'h5A3C), -1, 1'b0, 1);
    expectGood(16'hA7A7);
    sendFrame(16'hA7A7, crc8(16'hA7A7), -1, 1'b0, 0);
    $display("txn sync-lookalike payload: data=a7a7");

    for (int n = 0; n < 3; n++) begin
      d = 16'($urandom);
      expectGood(d);
      sendFrame(d, crc8(d), -1, 1'b0, 0);
    end
    huntIdle();
    $display("txn long idle in hunt");

    sendFrame(16'hBEEF, crc8(16'hBEEF), 8, 1'b1, 0);
    $display("txn reset mid-payload");
    expectGood(16'hBEEF);
    sendFrame(16'hBEEF, crc8(16'hBEEF), -1, 1'b0, 0);
    $display("txn post-reset frame: data=beef");

    for (int t = 0; t < 60; t++) begin
      d       = 16'($urandom);
      kind    = $urandom_range(0, 9);
      spacing = $urandom_range(1, 6);
      pre     = $urandom_range(0, 5);
      if (kind == 6 && NCRC == 0) kind = 0;
      if (kind <= 5) begin
        expectGood(d);
        sendFrame(d, crc8(d), -1, 1'b0, pre);
        $display("txn %0d good: data=%h spacing=%0d", t, d, spacing);
      end else if (kind == 6) begin
        flip = 8'h01 << $urandom_range(0, 7);
        expectErr();
        sendFrame(d, crc8(d) ^ flip, -1, 1'b0, pre);
        $display("txn %0d bad crc: data=%h flip=%h", t, d, flip);
      end else if (kind == 7) begin
        expectErr();
        sendFrame(d, crc8(d), $urandom_range(0, DATA_W + NCRC - 1), 1'b0, pre);
        $display("txn %0d gap abort: data=%h", t, d);
      end else if (kind == 8) begin
        sendFrame(d, crc8(d), $urandom_range(0, DATA_W + NCRC - 1), 1'b1, pre);
        $display("txn %0d reset mid-frame", t);
      end else begin
        huntIdle();
        $display("txn %0d long idle in hunt", t);
      end
    end

    repeat (10) cyc(1'b0, 1'b0);
    chk("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
